tcp_frame_builder: RTL and testbench

Transmit-side counterpart of the RX header parser. Accepts one header descriptor and a raw application payload stream, and emits a complete Ethernet/IPv4/TCP frame on a 512-bit AXIS master. The frame carries a fixed 54-byte header with no IP or TCP options, followed by the payload realigned by 54 bytes. The block sits between the application payload source and the Corundum TX queue, and computes the IPv4 header checksum internally.

---
 rtl/net_hdr_pkg.sv | 89 ++++++++
 rtl/ipv4_csum.sv | 22 ++
 rtl/tcp_frame_builder.sv | 199 +++++++++++++++++++
 tb/tb_tcp_frame_builder.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/net_hdr_pkg.sv
// Shared Ethernet/IPv4/TCP header definitions used by the TX frame builder and the RX parser.
// The header is 54 bytes with no IP or TCP options. Byte 0 is the first byte on the wire.
package net_hdr_pkg;

  localparam int ETH_HDR_LEN   = 14;
  localparam int IPV4_HDR_LEN  = 20;
  localparam int TCP_HDR_LEN   = 20;
  localparam int TOTAL_HDR_LEN = ETH_HDR_LEN + IPV4_HDR_LEN + TCP_HDR_LEN;
  localparam int HDR_BITS      = TOTAL_HDR_LEN * 8;

  localparam logic [15:0] ETHERTYPE_IPV4  = 16'h0800;
  localparam logic [7:0]  IP_PROTO_TCP    = 8'h06;
  localparam logic [7:0]  IP_TTL_DEFAULT  = 8'h40;
  localparam logic [7:0]  IP_VER_IHL      = 8'h45;
  localparam logic [15:0] IP_FLAGS_DF     = 16'h4000;
  localparam logic [7:0]  TCP_DATA_OFFSET = 8'h50;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [31:0] seq;
    logic [31:0] ack;
    logic [7:0]  tcp_flags;
    logic [15:0] window;
    logic [15:0] ip_id;
    logic [15:0] payload_len;
  } tx_hdr_desc_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CSUM,
    S_HDRONLY,
    S_HDR,
    S_BODY,
    S_FLUSH
  } tx_state_t;

  function automatic logic [15:0] ip_total_len(input logic [15:0] payload_len);
    return 16'(IPV4_HDR_LEN + TCP_HDR_LEN) + payload_len;
  endfunction

  // Byte lanes are little-endian in the vector, so network-order fields are byte-swapped.
  function automatic logic [15:0] be16(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  function automatic logic [31:0] be32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  // The ten IPv4 header words as numeric values, word k in bits [16k+15:16k].
  function automatic logic [159:0] ipv4_words(input tx_hdr_desc_t d);
    return {d.dst_ip[15:0], d.dst_ip[31:16], d.src_ip[15:0], d.src_ip[31:16],
            16'h0000, {IP_TTL_DEFAULT, IP_PROTO_TCP}, IP_FLAGS_DF, d.ip_id,
            ip_total_len(d.payload_len), {IP_VER_IHL, 8'h00}};
  endfunction

  function automatic logic [HDR_BITS-1:0] build_header(input tx_hdr_desc_t d,
                                                       input logic [15:0] csum);
    logic [HDR_BITS-1:0] h;
    h = '0;
    for (int i = 0; i < 6; i++) begin
      h[8*i +: 8]     = d.dst_mac[8*i +: 8];
      h[8*(6+i) +: 8] = d.src_mac[8*i +: 8];
    end
    h[8*12 +: 16] = be16(ETHERTYPE_IPV4);
    h[8*14 +: 16] = be16({IP_VER_IHL, 8'h00});
    h[8*16 +: 16] = be16(ip_total_len(d.payload_len));
    h[8*18 +: 16] = be16(d.ip_id);
    h[8*20 +: 16] = be16(IP_FLAGS_DF);
    h[8*22 +: 16] = be16({IP_TTL_DEFAULT, IP_PROTO_TCP});
    h[8*24 +: 16] = be16(csum);
    h[8*26 +: 32] = be32(d.src_ip);
    h[8*30 +: 32] = be32(d.dst_ip);
    h[8*34 +: 16] = be16(d.src_port);
    h[8*36 +: 16] = be16(d.dst_port);
    h[8*38 +: 32] = be32(d.seq);
    h[8*42 +: 32] = be32(d.ack);
    h[8*46 +: 16] = be16({TCP_DATA_OFFSET, d.tcp_flags});
    h[8*48 +: 16] = be16(d.window);
    // TCP checksum (left for MAC offload) and urgent pointer stay zero.
    return h;
  endfunction

endpackage

// File: rtl/ipv4_csum.sv
// Combinational IPv4 header checksum over ten 16-bit words (checksum word supplied as zero).
module ipv4_csum (
  input  logic [159:0] words_i,
  output logic [15:0]  csum_o
);

  logic [19:0] sum;
  logic [16:0] fold1;
  logic [15:0] fold2;

  // Ten 16-bit words fit in 20 bits; two folds always absorb every carry.
  always_comb begin
    sum = '0;
    for (int k = 0; k < 10; k++) begin
      sum = sum + {4'b0000, words_i[16*k +: 16]};
    end
    fold1  = {1'b0, sum[15:0]} + {13'b0, sum[19:16]};
    fold2  = fold1[15:0] + {15'b0, fold1[16]};
    csum_o = ~fold2;
  end

endmodule

// File: rtl/tcp_frame_builder.sv
// Builds Ethernet/IPv4/TCP frames from a header descriptor plus a payload stream,
// shifting the payload up by the 54-byte header on a 512-bit AXIS master.
module tcp_frame_builder
  import net_hdr_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic                       hdr_valid,
  output logic                       hdr_ready,
  input  logic [47:0]                hdr_dst_mac,
  input  logic [47:0]                hdr_src_mac,
  input  logic [31:0]                hdr_src_ip,
  input  logic [31:0]                hdr_dst_ip,
  input  logic [15:0]                hdr_src_port,
  input  logic [15:0]                hdr_dst_port,
  input  logic [31:0]                hdr_seq,
  input  logic [31:0]                hdr_ack,
  input  logic [7:0]                 hdr_tcp_flags,
  input  logic [15:0]                hdr_window,
  input  logic [15:0]                hdr_ip_id,
  input  logic [15:0]                hdr_payload_len,

  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,

  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,

  output logic                       busy,
  output logic [31:0]                frames_sent
);

  localparam int         TAIL_BITS  = AXIS_DATA_WIDTH - HDR_BITS;
  localparam logic [6:0] TAIL_BYTES = 7'(AXIS_KEEP_WIDTH - TOTAL_HDR_LEN);
  localparam logic [6:0] HDR_BYTES  = 7'(TOTAL_HDR_LEN);

  tx_state_t           state_q, state_d;
  tx_hdr_desc_t        desc_q, desc_d, desc_in;
  logic [15:0]         csum_q, csum_d, csum_calc;
  logic [HDR_BITS-1:0] res_q, res_d;
  logic [6:0]          nres_q, nres_d;
  logic [31:0]         frames_q, frames_d;

  logic [159:0]        csum_words;
  logic [HDR_BITS-1:0] hdr_bytes;
  logic [6:0]          in_cnt;
  logic                last_short;

  function automatic logic [AXIS_KEEP_WIDTH-1:0] low_mask(input logic [6:0] n);
    logic [AXIS_KEEP_WIDTH:0] one;
    logic [AXIS_KEEP_WIDTH:0] t;
    one    = '0;
    one[0] = 1'b1;
    t      = (one << n) - one;
    return t[AXIS_KEEP_WIDTH-1:0];
  endfunction

  assign desc_in = '{dst_mac:     hdr_dst_mac,
                     src_mac:     hdr_src_mac,
                     src_ip:      hdr_src_ip,
                     dst_ip:      hdr_dst_ip,
                     src_port:    hdr_src_port,
                     dst_port:    hdr_dst_port,
                     seq:         hdr_seq,
                     ack:         hdr_ack,
                     tcp_flags:   hdr_tcp_flags,
                     window:      hdr_window,
                     ip_id:       hdr_ip_id,
                     payload_len: hdr_payload_len};

  assign csum_words = ipv4_words(desc_q);
  assign hdr_bytes  = build_header(desc_q, csum_q);

  ipv4_csum u_csum (
    .words_i (csum_words),
    .csum_o  (csum_calc)
  );

  // tkeep is contiguous from the LSB, so its population count is the byte count.
  always_comb begin
    in_cnt = '0;
    for (int i = 0; i < AXIS_KEEP_WIDTH; i++) begin
      in_cnt = in_cnt + {6'b0, s_axis_tkeep[i]};
    end
  end

  assign last_short  = s_axis_tlast && (in_cnt <= TAIL_BYTES);
  assign busy        = (state_q != S_IDLE);
  assign frames_sent = frames_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      desc_q   <= '0;
      csum_q   <= '0;
      res_q    <= '0;
      nres_q   <= '0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      desc_q   <= desc_d;
      csum_q   <= csum_d;
      res_q    <= res_d;
      nres_q   <= nres_d;
      frames_q <= frames_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    desc_d        = desc_q;
    csum_d        = csum_q;
    res_d         = res_q;
    nres_d        = nres_q;
    frames_d      = frames_q;
    hdr_ready     = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;

    case (state_q)
      S_IDLE: begin
        hdr_ready = 1'b1;
        if (hdr_valid) begin
          desc_d  = desc_in;
          state_d = S_CSUM;
        end
      end

      S_CSUM: begin
        csum_d  = csum_calc;
        state_d = (desc_q.payload_len == 16'd0) ? S_HDRONLY : S_HDR;
      end

      S_HDRONLY: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = {{TAIL_BITS{1'b0}}, hdr_bytes};
        m_axis_tkeep  = low_mask(HDR_BYTES);
        m_axis_tlast  = 1'b1;
        if (m_axis_tready) begin
          state_d = S_IDLE;
        end
      end

      // Pass-through beats: the low 54 bytes are the header or the carried residual,
      // the top 10 bytes are the head of the current input beat.
      S_HDR, S_BODY: begin
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
        m_axis_tdata  = {s_axis_tdata[TAIL_BITS-1:0],
                         (state_q == S_HDR) ? hdr_bytes : res_q};
        m_axis_tkeep  = last_short ? low_mask(HDR_BYTES + in_cnt) : '1;
        m_axis_tlast  = last_short;
        if (s_axis_tvalid && m_axis_tready) begin
          res_d  = s_axis_tdata[AXIS_DATA_WIDTH-1:TAIL_BITS];
          nres_d = (in_cnt > TAIL_BYTES) ? (in_cnt - TAIL_BYTES) : '0;
          if (!s_axis_tlast) begin
            state_d = S_BODY;
          end else if (last_short) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_FLUSH;
          end
        end
      end

      S_FLUSH: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = {{TAIL_BITS{1'b0}}, res_q};
        m_axis_tkeep  = low_mask(nres_q);
        m_axis_tlast  = 1'b1;
        if (m_axis_tready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
      frames_d = frames_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_tcp_frame_builder.sv
// Bench for tcp_frame_builder: each frame is modelled as a flat byte array (header + payload)
// and every output beat is compared against its 64-byte slice of that array.
module tb_tcp_frame_builder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         hdr_valid = 1'b0;
  logic         hdr_ready;
  logic [47:0]  hdr_dst_mac = '0;
  logic [47:0]  hdr_src_mac = '0;
  logic [31:0]  hdr_src_ip = '0;
  logic [31:0]  hdr_dst_ip = '0;
  logic [15:0]  hdr_src_port = '0;
  logic [15:0]  hdr_dst_port = '0;
  logic [31:0]  hdr_seq = '0;
  logic [31:0]  hdr_ack = '0;
  logic [7:0]   hdr_tcp_flags = '0;
  logic [15:0]  hdr_window = '0;
  logic [15:0]  hdr_ip_id = '0;
  logic [15:0]  hdr_payload_len = '0;
  logic [511:0] s_axis_tdata = '0;
  logic [63:0]  s_axis_tkeep = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic         s_axis_tlast = 1'b0;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b1;
  logic         m_axis_tlast;
  logic         busy;
  logic [31:0]  frames_sent;

  int           total = 0;
  int           bad = 0;
  int           framesExp = 0;
  logic [7:0]   payload[$];
  logic [7:0]   expBytes[$];
  logic [511:0] firstBeat = '0;

  tcp_frame_builder #(
    .AXIS_DATA_WIDTH (512),
    .AXIS_KEEP_WIDTH (64)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .hdr_valid       (hdr_valid),
    .hdr_ready       (hdr_ready),
    .hdr_dst_mac     (hdr_dst_mac),
    .hdr_src_mac     (hdr_src_mac),
    .hdr_src_ip      (hdr_src_ip),
    .hdr_dst_ip      (hdr_dst_ip),
    .hdr_src_port    (hdr_src_port),
    .hdr_dst_port    (hdr_dst_port),
    .hdr_seq         (hdr_seq),
    .hdr_ack         (hdr_ack),
    .hdr_tcp_flags   (hdr_tcp_flags),
    .hdr_window      (hdr_window),
    .hdr_ip_id       (hdr_ip_id),
    .hdr_payload_len (hdr_payload_len),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tkeep    (s_axis_tkeep),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tlast    (s_axis_tlast),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tkeep    (m_axis_tkeep),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tlast    (m_axis_tlast),
    .busy            (busy),
    .frames_sent     (frames_sent)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] lowMask(input int n);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic randomDescriptor(input int len);
    hdr_dst_mac     = 48'({$urandom(), $urandom()});
    hdr_src_mac     = 48'({$urandom(), $urandom()});
    hdr_src_ip      = $urandom();
    hdr_dst_ip      = $urandom();
    hdr_src_port    = 16'($urandom());
    hdr_dst_port    = 16'($urandom());
    hdr_seq         = $urandom();
    hdr_ack         = $urandom();
    hdr_tcp_flags   = 8'($urandom());
    hdr_window      = 16'($urandom());
    hdr_ip_id       = 16'($urandom());
    hdr_payload_len = 16'(len);
  endtask

  task automatic pushBe(input logic [31:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) expBytes.push_back(v[8*k +: 8]);
  endtask

  // Reference frame: wire bytes written out field by field, then the payload.
  task automatic buildExpected();
    int unsigned sum;
    logic [15:0] csum;
    logic [15:0] totLen;
    expBytes.delete();
    totLen = 16'(40 + int'(hdr_payload_len));
    for (int i = 0; i < 6; i++) expBytes.push_back(hdr_dst_mac[8*i +: 8]);
    for (int i = 0; i < 6; i++) expBytes.push_back(hdr_src_mac[8*i +: 8]);
    pushBe(32'h0800, 2);
    pushBe(32'h4500, 2);
    pushBe({16'h0, totLen}, 2);
    pushBe({16'h0, hdr_ip_id}, 2);
    pushBe(32'h4000, 2);
    pushBe(32'h4006, 2);
    pushBe(32'h0000, 2);
    pushBe(hdr_src_ip, 4);
    pushBe(hdr_dst_ip, 4);
    pushBe({16'h0, hdr_src_port}, 2);
    pushBe({16'h0, hdr_dst_port}, 2);
    pushBe(hdr_seq, 4);
    pushBe(hdr_ack, 4);
    expBytes.push_back(8'h50);
    expBytes.push_back(hdr_tcp_flags);
    pushBe({16'h0, hdr_window}, 2);
    pushBe(32'h0000, 4);
    sum = 0;
    for (int k = 0; k < 10; k++) sum += {expBytes[14 + 2*k], expBytes[15 + 2*k]};
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
    csum = ~sum[15:0];
    expBytes[24] = csum[15:8];
    expBytes[25] = csum[7:0];
    foreach (payload[i]) expBytes.push_back(payload[i]);
  endtask

  task automatic driveInput(input int idx, input int inBeats, input int len);
    int n;
    if (idx < inBeats) begin
      n = len - 64*idx;
      if (n > 64) n = 64;
      for (int b = 0; b < 64; b++)
        s_axis_tdata[8*b +: 8] = (b < n) ? payload[64*idx + b] : 8'(8'hE0 + b);
      s_axis_tkeep  = lowMask(n);
      s_axis_tlast  = (idx == inBeats - 1);
      s_axis_tvalid = 1'b1;
    end else begin
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tlast  = 1'b0;
      s_axis_tvalid = 1'b0;
    end
  endtask

  // Runs one frame; abortAfter >= 0 pulses rst once that many output beats have gone out.
  task automatic applyStimulus(input int len, input bit randReady, input int abortAfter);
    int inBeats, inIdx, outIdx, expBeats, totalLen, cycles, cnt;
    bit done, held;
    logic [511:0] heldData, expData, mask;
    logic [63:0] heldKeep;
    logic heldLast;
    payload.delete();
    for (int i = 0; i < len; i++) payload.push_back(8'($urandom()));
    buildExpected();
    totalLen = 54 + len;
    expBeats = (totalLen + 63) / 64;
    inBeats  = (len + 63) / 64;
    heldData = '0;
    heldKeep = '0;
    heldLast = 1'b0;

    @(negedge clk);
    hdr_valid = 1'b1;
    inIdx = 0;
    driveInput(inIdx, inBeats, len);
    m_axis_tready = 1'b1;
    #1 checkOutput("hdr_ready_idle", hdr_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    hdr_valid = 1'b0;
    #1;
    checkOutput("csum_cycle_tvalid", m_axis_tvalid, 1'b0);
    checkOutput("csum_cycle_busy", busy, 1'b1);
    checkOutput("csum_cycle_hdr_ready", hdr_ready, 1'b0);
    @(posedge clk);

    outIdx = 0;
    cycles = 0;
    done = 1'b0;
    held = 1'b0;
    while (!done && cycles < 3000) begin
      @(negedge clk);
      cycles++;
      if (abortAfter >= 0 && outIdx == abortAfter) begin
        rst = 1'b1;
        #1;
        checkOutput("rst_tvalid", m_axis_tvalid, 1'b0);
        checkOutput("rst_tdata", m_axis_tdata, 512'h0);
        checkOutput("rst_tkeep", m_axis_tkeep, 64'h0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_frames_sent", frames_sent, framesExp);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        driveInput(inBeats, inBeats, len);
        #1;
        checkOutput("post_rst_tvalid", m_axis_tvalid, 1'b0);
        checkOutput("post_rst_hdr_ready", hdr_ready, 1'b1);
        return;
      end
      driveInput(inIdx, inBeats, len);
      m_axis_tready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (cycles == 1) checkOutput("first_beat_latency", m_axis_tvalid, 1'b1);
      if (len == 0) checkOutput("hdronly_s_tready", s_axis_tready, 1'b0);
      if (held) begin
        checkOutput("held_tvalid", m_axis_tvalid, 1'b1);
        checkOutput("held_tdata", m_axis_tdata, heldData);
        checkOutput("held_tkeep", m_axis_tkeep, heldKeep);
        checkOutput("held_tlast", m_axis_tlast, heldLast);
      end
      held     = m_axis_tvalid && !m_axis_tready;
      heldData = m_axis_tdata;
      heldKeep = m_axis_tkeep;
      heldLast = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        cnt = totalLen - 64*outIdx;
        if (cnt > 64) cnt = 64;
        expData = '0;
        mask    = '0;
        for (int b = 0; b < 64; b++) begin
          if (b < cnt) begin
            expData[8*b +: 8] = expBytes[64*outIdx + b];
            mask[8*b +: 8]    = 8'hFF;
          end
        end
        checkOutput("beat_tkeep", m_axis_tkeep, lowMask(cnt));
        checkOutput("beat_tlast", m_axis_tlast, (outIdx == expBeats - 1));
        checkOutput("beat_tdata", m_axis_tdata & mask, expData);
        if (outIdx == 0) firstBeat = m_axis_tdata;
        outIdx++;
        if (m_axis_tlast || outIdx > expBeats) done = 1'b1;
      end
      if (s_axis_tvalid && s_axis_tready) inIdx++;
      @(posedge clk);
    end
    checkOutput("frame_completed", done, 1'b1);
    checkOutput("beat_count", outIdx, expBeats);
    checkOutput("input_consumed", inIdx, inBeats);
    framesExp++;
    @(negedge clk);
    driveInput(inBeats, inBeats, len);
    m_axis_tready = 1'b1;
    #1;
    checkOutput("frames_sent", frames_sent, framesExp);
    checkOutput("idle_busy", busy, 1'b0);
    checkOutput("idle_hdr_ready", hdr_ready, 1'b1);
  endtask

  initial begin
    int len;
    $display("[TB] starting tcp_frame_builder bench");
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset_tvalid", m_axis_tvalid, 1'b0);
    checkOutput("reset_tlast", m_axis_tlast, 1'b0);
    checkOutput("reset_tdata", m_axis_tdata, 512'h0);
    checkOutput("reset_tkeep", m_axis_tkeep, 64'h0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_frames_sent", frames_sent, 32'h0);
    rst = 1'b0;
    #1 checkOutput("reset_hdr_ready", hdr_ready, 1'b1);

    $display("[TB] reset pulse in the middle of a long frame");
    randomDescriptor(1460);
    applyStimulus(1460, 1'b0, 3);

    $display("[TB] header-only frame 10.0.0.1 -> 10.0.0.2");
    randomDescriptor(0);
    hdr_src_ip = 32'h0A000001;
    hdr_dst_ip = 32'h0A000002;
    hdr_ip_id  = 16'h0000;
    applyStimulus(0, 1'b0, -1);
    checkOutput("len0_total_length", {firstBeat[8*16 +: 8], firstBeat[8*17 +: 8]}, 16'h0028);
    checkOutput("len0_ip_csum", {firstBeat[8*24 +: 8], firstBeat[8*25 +: 8]}, 16'h26CE);

    $display("[TB] payload length boundaries");
    randomDescriptor(10);
    applyStimulus(10, 1'b0, -1);
    randomDescriptor(11);
    applyStimulus(11, 1'b0, -1);
    randomDescriptor(128);
    applyStimulus(128, 1'b0, -1);
    checkOutput("len128_total_length", {firstBeat[8*16 +: 8], firstBeat[8*17 +: 8]}, 16'h00A8);

    $display("[TB] max payload with random backpressure");
    randomDescriptor(1460);
    applyStimulus(1460, 1'b1, -1);

    $display("[TB] random frames");
    for (int f = 0; f < 6; f++) begin
      len = (f % 2 == 0) ? int'($urandom_range(1, 140)) : int'($urandom_range(1, 1460));
      randomDescriptor(len);
      applyStimulus(len, 1'b1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
